// File: rtl/ahfp_pkg.sv
// Shared constants and types for the ahfp floating-point custom-instruction family.
// Holds the default field widths, the pipeline depth and the operand class encoding.
package ahfp_pkg;

  localparam int unsigned DefExpW = 8;
  localparam int unsigned DefManW = 23;
  localparam int unsigned STAGES  = 4;
  localparam int unsigned MaxW    = 64;

  typedef enum logic [1:0] {
    ClsZero,
    ClsNorm,
    ClsInf,
    ClsNan
  } fp_class_e;

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set. Callers truncate to width.
  function automatic logic [MaxW-1:0] qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [MaxW-1:0] ones;
    ones = (MaxW'(1) << exp_w) - MaxW'(1);
    return (ones << man_w) | (MaxW'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/ahfp_lzc.sv
// Leading-zero counter; an all-zero input reports the full input width.
module ahfp_lzc #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned CntW  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CntW-1:0]  count_o
);

  // Scan upward so the most significant set bit wins.
  always_comb begin
    count_o = CntW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        count_o = CntW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/ahfp_addsub_pipe.sv
// Pipelined floating-point add/subtract with round-to-nearest-even and a start/done interface.
// Operands are captured, then aligned, added, normalised and rounded in four stages.
module ahfp_addsub_pipe
  import ahfp_pkg::*;
#(
  parameter int unsigned EXP_W = DefExpW,
  parameter int unsigned MAN_W = DefManW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic                 n,
  input  logic [EXP_W+MAN_W:0] dataa,
  input  logic [EXP_W+MAN_W:0] datab,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 done
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned XW = MAN_W + 4;
  localparam int unsigned SW = MAN_W + 5;
  localparam int unsigned CW = $clog2(MAN_W + 6);
  localparam int unsigned NE = EXP_W + 2;
  localparam int unsigned MR = MAN_W + 2;
  localparam logic [EXP_W-1:0] ExpOnes = '1;
  localparam logic [W-1:0]     QNan    = W'(qnan(EXP_W, MAN_W));

  typedef struct packed {
    logic             valid;
    logic             special;
    logic [W-1:0]     spec_val;
    logic             sign;
    logic             both_neg;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [XW-1:0]    mx;
    logic [XW-1:0]    my;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             special;
    logic [W-1:0]     spec_val;
    logic             sign;
    logic             both_neg;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sum;
  } s2_t;

  typedef struct packed {
    logic          valid;
    logic          special;
    logic [W-1:0]  spec_val;
    logic          sign;
    logic          both_neg;
    logic          zero;
    logic          uflow;
    logic [NE-1:0] exp;
    logic [XW-1:0] m;
  } s3_t;

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return ClsZero;
    if (e == ExpOnes) return (f == '0) ? ClsInf : ClsNan;
    return ClsNorm;
  endfunction

  logic          in_valid_q;
  logic [W-1:0]  a_q, b_q;
  logic          n_q;
  s1_t           s1_d, s1_q;
  s2_t           s2_d, s2_q;
  s3_t           s3_d, s3_q;
  logic          done_q;
  logic [W-1:0]  result_q, res_d;

  // ---------------- S1: decode, order and align ----------------
  logic             sa, sb_eff, sub, sign_x, a_ge;
  logic [EXP_W-1:0] ea, eb, ex, ey, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   man_a, man_b, man_x, man_y;
  logic [XW-1:0]    y_ext, y_sh, lost_mask;
  fp_class_e        cls_a, cls_b;

  assign sa     = a_q[W-1];
  assign sb_eff = b_q[W-1] ^ n_q;
  assign sub    = sa ^ sb_eff;
  assign ea     = a_q[MAN_W +: EXP_W];
  assign eb     = b_q[MAN_W +: EXP_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];

  always_comb begin
    cls_a = classify(ea, fa);
    cls_b = classify(eb, fb);
    // Denormals flush to zero: no hidden bit and the stored fraction is ignored.
    man_a = (cls_a == ClsZero) ? '0 : {1'b1, fa};
    man_b = (cls_b == ClsZero) ? '0 : {1'b1, fb};
    a_ge  = {ea, man_a} >= {eb, man_b};
    if (a_ge) begin
      ex = ea; ey = eb; man_x = man_a; man_y = man_b; sign_x = sa;
    end else begin
      ex = eb; ey = ea; man_x = man_b; man_y = man_a; sign_x = sb_eff;
    end
    diff      = ex - ey;
    y_ext     = {man_y, 3'b000};
    y_sh      = '0;
    lost_mask = '0;
    if (32'(diff) >= MAN_W + 3) begin
      y_sh = XW'(|man_y);
    end else begin
      y_sh      = y_ext >> diff;
      lost_mask = (XW'(1) << diff) - XW'(1);
      y_sh[0]   = y_sh[0] | (|(y_ext & lost_mask));
    end

    s1_d.valid    = in_valid_q;
    s1_d.special  = 1'b0;
    s1_d.spec_val = QNan;
    s1_d.sign     = sign_x;
    s1_d.both_neg = sa & sb_eff;
    s1_d.sub      = sub;
    s1_d.exp      = ex;
    s1_d.mx       = {man_x, 3'b000};
    s1_d.my       = y_sh;
    if (cls_a == ClsNan || cls_b == ClsNan) begin
      s1_d.special = 1'b1;
    end else if (cls_a == ClsInf && cls_b == ClsInf) begin
      s1_d.special  = 1'b1;
      s1_d.spec_val = sub ? QNan : {sa, ExpOnes, {MAN_W{1'b0}}};
    end else if (cls_a == ClsInf) begin
      s1_d.special  = 1'b1;
      s1_d.spec_val = {sa, ExpOnes, {MAN_W{1'b0}}};
    end else if (cls_b == ClsInf) begin
      s1_d.special  = 1'b1;
      s1_d.spec_val = {sb_eff, ExpOnes, {MAN_W{1'b0}}};
    end
  end

  // ---------------- S2: mantissa add/subtract ----------------
  always_comb begin
    s2_d.valid    = s1_q.valid;
    s2_d.special  = s1_q.special;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.sign     = s1_q.sign;
    s2_d.both_neg = s1_q.both_neg;
    s2_d.exp      = s1_q.exp;
    // X >= Y in magnitude, so the difference never goes negative.
    s2_d.sum      = s1_q.sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                             : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
  end

  // ---------------- S3: normalise ----------------
  logic [CW-1:0] lzc, shift;

  ahfp_lzc #(
    .WIDTH(SW),
    .CntW (CW)
  ) u_lzc (
    .data_i (s2_q.sum),
    .count_o(lzc)
  );

  always_comb begin
    s3_d.valid    = s2_q.valid;
    s3_d.special  = s2_q.special;
    s3_d.spec_val = s2_q.spec_val;
    s3_d.sign     = s2_q.sign;
    s3_d.both_neg = s2_q.both_neg;
    s3_d.zero     = 1'b0;
    // The carry position always counts as one leading zero when it is clear.
    shift         = lzc - CW'(1);
    if (s2_q.sum[SW-1]) begin
      s3_d.m   = s2_q.sum[SW-1:1] | XW'(s2_q.sum[0]);
      s3_d.exp = NE'(s2_q.exp) + NE'(1);
    end else begin
      s3_d.m    = s2_q.sum[XW-1:0] << shift;
      s3_d.exp  = NE'(s2_q.exp) - NE'(shift);
      s3_d.zero = (s2_q.sum == '0);
    end
    s3_d.uflow = s3_d.exp[NE-1] || (s3_d.exp == '0);
  end

  // ---------------- S4: round and pack ----------------
  logic          rnd_up;
  logic [MR-1:0] mant_r;
  logic [NE-1:0] exp_r;
  logic [MAN_W-1:0] frac_r;

  always_comb begin
    rnd_up = s3_q.m[2] & (s3_q.m[1] | s3_q.m[0] | s3_q.m[3]);
    mant_r = {1'b0, s3_q.m[XW-1:3]} + MR'(rnd_up);
    exp_r  = s3_q.exp;
    frac_r = mant_r[MAN_W-1:0];
    if (mant_r[MAN_W+1]) begin
      exp_r  = s3_q.exp + NE'(1);
      frac_r = mant_r[MAN_W:1];
    end
    if (s3_q.special) begin
      res_d = s3_q.spec_val;
    end else if (s3_q.zero) begin
      res_d = {s3_q.both_neg, {(W-1){1'b0}}};
    end else if (s3_q.uflow) begin
      res_d = {s3_q.sign, {(W-1){1'b0}}};
    end else if (exp_r >= NE'(ExpOnes)) begin
      res_d = {s3_q.sign, ExpOnes, {MAN_W{1'b0}}};
    end else begin
      res_d = {s3_q.sign, exp_r[EXP_W-1:0], frac_r};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_valid_q  <= 1'b0;
      s1_q.valid  <= 1'b0;
      s2_q.valid  <= 1'b0;
      s3_q.valid  <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else if (clk_en) begin
      in_valid_q <= start;
      a_q        <= dataa;
      b_q        <= datab;
      n_q        <= n;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      done_q     <= s3_q.valid;
      if (s3_q.valid) begin
        result_q <= res_d;
      end
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// Randomised bench for ahfp_addsub_pipe against an exact-arithmetic reference model.
module tb_ahfp_addsub_pipe;
  import ahfp_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clk_en, start, n;
  logic [31:0] dataa, datab, result;
  logic        done;

  always #5 clk = ~clk;

  ahfp_addsub_pipe dut (
    .clk   (clk),
    .reset (reset),
    .clk_en(clk_en),
    .start (start),
    .n     (n),
    .dataa (dataa),
    .datab (datab),
    .result(result),
    .done  (done)
  );

  typedef struct packed {
    logic [31:0] val;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          errors = 0;
  int          checks = 0;
  int          en_cnt = 0;
  logic        last_upd = 1'b0;
  logic        last_rst = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] prev_result = '0;
  logic [31:0] ra, rb;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endfunction

  // Exact sum in units of 2^-149, then round to nearest even and pack.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic nb);
    logic         sa, sb, sx;
    int           ea, eb, p, sh, be;
    logic [299:0] va, vb, v, sig, rem, half;
    logic         a_nan, b_nan, a_inf, b_inf;
    sa    = a[31];
    sb    = b[31] ^ nb;
    ea    = int'(a[30:23]);
    eb    = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (sa != sb) ? 32'h7FC0_0000 : {sa, 8'hFF, 23'h0};
    if (a_inf) return {sa, 8'hFF, 23'h0};
    if (b_inf) return {sb, 8'hFF, 23'h0};
    va = (ea == 0) ? '0 : (300'({1'b1, a[22:0]}) << (ea - 1));
    vb = (eb == 0) ? '0 : (300'({1'b1, b[22:0]}) << (eb - 1));
    if (sa == sb) begin
      v = va + vb; sx = sa;
    end else if (va > vb) begin
      v = va - vb; sx = sa;
    end else begin
      v = vb - va; sx = sb;
    end
    if (v == 0) return {sa & sb, 31'h0};
    p = 0;
    for (int i = 0; i < 300; i++) if (v[i]) p = i;
    be = p - 22;
    if (be <= 0) return {sx, 31'h0};
    sh  = p - 23;
    sig = v >> sh;
    if (sh > 0) begin
      rem  = v & ((300'(1) << sh) - 300'(1));
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && sig[0])) sig = sig + 300'(1);
    end
    if (sig[24]) begin
      sig = sig >> 1;
      be  = be + 1;
    end
    if (be >= 255) return {sx, 8'hFF, 23'h0};
    return {sx, 8'(be), sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 15))
      0:       r[30:0] = '0;
      1:       begin r[30:23] = 8'hFF; r[22:0] = '0; end
      2:       begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      3:       r[30:23] = '0;
      4, 5, 6, 7, 8, 9: r[30:23] = 8'(124 + $urandom_range(0, 6));
      10:      r[30:23] = 8'(250 + $urandom_range(0, 4));
      11:      r[30:23] = 8'($urandom_range(1, 3));
      default: r[30:23] = 8'($urandom_range(1, 254));
    endcase
    return r;
  endfunction

  // Record exactly what the DUT samples on each edge.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      last_rst <= 1'b1;
      last_upd <= 1'b0;
    end else begin
      last_rst <= 1'b0;
      last_upd <= clk_en;
      if (clk_en) begin
        en_cnt <= en_cnt + 1;
        if (start) exp_q.push_back('{val: model(dataa, datab, n), issue: en_cnt + 1});
      end
    end
  end

  always @(negedge clk) begin
    if (last_rst) begin
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", result, 32'd0);
    end else if (last_upd) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with result 0x%08h, want no done", result);
        end else begin
          cur = exp_q.pop_front();
          chk("result", result, cur.val);
          chk("latency", en_cnt - cur.issue, STAGES);
        end
      end
    end else begin
      chk("hold_done", 32'(done), 32'(prev_done));
      chk("hold_result", result, prev_result);
    end
    prev_done   = done;
    prev_result = result;
  end

  task automatic cyc(input logic st, input logic [31:0] a, input logic [31:0] b,
                     input logic nn, input logic en);
    @(negedge clk);
    start  = st;
    dataa  = a;
    datab  = b;
    n      = nn;
    clk_en = en;
  endtask

  logic [31:0] pa[9] = '{32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000,
                         32'h3F80_0000, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h7F80_0000,
                         32'h7FA0_0000};
  logic [31:0] pb[9] = '{32'h3F80_0000, 32'h4040_0000, 32'hBF80_0000, 32'h8000_0000,
                         32'h3380_0000, 32'h3380_0001, 32'h7F7F_FFFF, 32'h7F80_0000,
                         32'h3F80_0000};
  logic        pn[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] pr[9] = '{32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 32'h8000_0000,
                         32'h3F80_0000, 32'h3F80_0001, 32'h7F80_0000, 32'h7FC0_0000,
                         32'h7FC0_0000};

  initial begin
    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    n      = 1'b0;
    dataa  = '0;
    datab  = '0;

    for (int i = 0; i < 9; i++) chk($sformatf("model_pin%0d", i), model(pa[i], pb[i], pn[i]), pr[i]);

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Isolated first op, then the rest of the directed vectors back to back.
    cyc(1'b1, pa[0], pb[0], pn[0], 1'b1);
    repeat (6) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 1; i < 9; i++) cyc(1'b1, pa[i], pb[i], pn[i], 1'b1);
    repeat (8) cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // Stream of four with a two-cycle freeze in the middle.
    cyc(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b0, 1'b1);
    cyc(1'b1, 32'h4120_0000, 32'h3F00_0000, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC2C8_0000, 32'h42C8_0001, 1'b0, 1'b1);
    cyc(1'b1, 32'h3F80_0000, 32'h3380_0001, 1'b0, 1'b1);
    repeat (8) cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // Reset with three ops in flight; reset must win over clk_en=0 and ignore start.
    cyc(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b1);
    cyc(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b1);
    cyc(1'b1, 32'h4080_0000, 32'h3F80_0000, 1'b0, 1'b1);
    @(negedge clk);
    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    start  = 1'b0;
    clk_en = 1'b1;
    repeat (8) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("post_reset_result", result, 32'd0);
    chk("post_reset_done", 32'(done), 32'd0);

    for (int i = 0; i < 400; i++) begin
      ra = rand_fp();
      rb = ($urandom_range(0, 4) == 0) ? (ra ^ ($urandom & 32'h8000_000F)) : rand_fp();
      cyc(1'($urandom_range(0, 9) < 7), ra, rb, 1'($urandom & 1), 1'($urandom_range(0, 9) < 8));
    end

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
